output_pipeline: RTL and testbench

Final stage of the histogram equalizer, and the read-side counterpart of the input pipeline. It consumes the 256-entry CDF table in scratchpad m2 and builds an internal 256×8 equalization LUT using a sequential divider. It then streams the image copy from scratchpad m3, 16 pixels per 128-bit word, maps every byte through the LUT and writes the equalized words to output memory m4 at the same addresses.

---
 rtl/output_pipeline.sv | 185 ++++++++++++++++++
 tb/tb_output_pipeline.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/output_pipeline.sv
// Histogram-equalizer output stage: builds a 256-entry equalization LUT from the
// CDF in m2 with a serial divider, then streams m3 through it into m4.
module output_lane #(
  parameter int VEC_W = 8
) (
  input  logic [(1<<VEC_W)-1:0][VEC_W-1:0] lut,
  input  logic [VEC_W-1:0]                 pix,
  output logic [VEC_W-1:0]                 eq
);
  assign eq = lut[pix];
endmodule

module output_pipeline #(
  parameter logic [14:0] ADDRESS_OF_LAST = 15'd19199,
  parameter logic [19:0] TOTAL_PIXELS    = 20'd307200,
  parameter int          NUM_LANES       = 16,
  parameter int          VEC_W           = 8
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       inputBaseOffset,
  input  logic [19:0]                cdf_min,
  input  logic [35:0]                m2ReadBus,
  input  logic [NUM_LANES*VEC_W-1:0] m3ReadBus,
  output logic [15:0]                m2ReadAddr,
  output logic [15:0]                m3ReadAddr,
  output logic [15:0]                m4WriteAddr,
  output logic [NUM_LANES*VEC_W-1:0] m4WriteBus,
  output logic                       m4WE,
  output logic                       output_done
);
  localparam int STAGES = 2;
  localparam int DIV_W  = 28;

  typedef enum logic [2:0] {
    IDLE, LUT_READ, LUT_LOAD, LUT_DIV, LUT_STORE, MAP, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic [20:0]      rem;
    logic [DIV_W-1:0] quo;
  } div_st;

  state_t                          state, next_state;
  div_st                           div_q, div_step;
  logic [7:0]                      v;
  logic [14:0]                     w;
  logic [4:0]                      div_cnt;
  logic                            drain_cnt;
  logic [STAGES:0]                 vld_pipe;
  logic [15:0]                     addr_d1;
  logic [(1<<VEC_W)-1:0][VEC_W-1:0] lut;
  logic [VEC_W-1:0]                lut_wdata;
  logic [19:0]                     c, den, diff;
  logic [DIV_W-1:0]                num;
  logic                            skip, abort;
  logic [20:0]                     shifted;
  logic [NUM_LANES-1:0][VEC_W-1:0] pix, eq;
  logic                            unused_bits;

  assign unused_bits = ^m2ReadBus[35:20];

  assign c    = m2ReadBus[19:0];
  assign den  = TOTAL_PIXELS - cdf_min;
  assign diff = c - cdf_min;
  // +den/2 turns the truncating divide into round-to-nearest
  assign num  = {8'd0, diff} * 28'd255 + {9'd0, den[19:1]};
  assign skip = (c < cdf_min) || (den == 20'd0);

  assign shifted   = {div_q.rem[19:0], div_q.quo[DIV_W-1]};
  assign lut_wdata = (|div_q.quo[DIV_W-1:VEC_W]) ? '1 : div_q.quo[VEC_W-1:0];

  always_comb begin
    div_step = div_q;
    if (shifted >= {1'b0, den}) begin
      div_step.rem = shifted - {1'b0, den};
      div_step.quo = {div_q.quo[DIV_W-2:0], 1'b1};
    end else begin
      div_step.rem = shifted;
      div_step.quo = {div_q.quo[DIV_W-2:0], 1'b0};
    end
  end

  assign abort = (state != IDLE) && !start;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = LUT_READ;
      LUT_READ:  next_state = LUT_LOAD;
      LUT_LOAD:  next_state = skip ? LUT_STORE : LUT_DIV;
      LUT_DIV:   if (div_cnt == 5'd27) next_state = LUT_STORE;
      LUT_STORE: next_state = (v == 8'hFF) ? MAP : LUT_READ;
      MAP:       if (w == ADDRESS_OF_LAST) next_state = DRAIN;
      DRAIN:     if (drain_cnt) next_state = DONE;
      DONE:      next_state = DONE;
      default:   next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      v           <= '0;
      w           <= '0;
      div_cnt     <= '0;
      drain_cnt   <= 1'b0;
      vld_pipe    <= '0;
      div_q       <= '0;
      addr_d1     <= '0;
      m2ReadAddr  <= '0;
      m3ReadAddr  <= '0;
      m4WriteAddr <= '0;
      m4WriteBus  <= '0;
      output_done <= 1'b0;
    end else begin
      state       <= next_state;
      output_done <= (next_state == DONE);
      // abort drops every word still in flight
      vld_pipe    <= abort ? '0 : {vld_pipe[STAGES-1:0], next_state == MAP};
      if (vld_pipe[0]) addr_d1 <= m3ReadAddr;
      if (vld_pipe[1] && !abort) begin
        m4WriteBus  <= eq;
        m4WriteAddr <= addr_d1;
      end
      if (abort) begin
        m3ReadAddr <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            v          <= '0;
            w          <= '0;
            m2ReadAddr <= '0;
          end
          LUT_LOAD: begin
            div_cnt     <= '0;
            div_q.rem   <= '0;
            div_q.quo   <= skip ? '0 : num;
          end
          LUT_DIV: begin
            div_q   <= div_step;
            div_cnt <= div_cnt + 5'd1;
          end
          LUT_STORE: begin
            if (v == 8'hFF) begin
              w          <= '0;
              m3ReadAddr <= {inputBaseOffset, 15'd0};
            end else begin
              v          <= v + 8'd1;
              m2ReadAddr <= {8'h00, v + 8'd1};
            end
          end
          MAP: begin
            drain_cnt <= 1'b0;
            if (w != ADDRESS_OF_LAST) begin
              w          <= w + 15'd1;
              m3ReadAddr <= {inputBaseOffset, w + 15'd1};
            end
          end
          DRAIN:   drain_cnt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign m4WE = vld_pipe[STAGES];

  // LUT contents need no reset; every entry is rewritten before MAP reads it
  always_ff @(posedge clock) begin
    if (!rst && state == LUT_STORE) lut[v] <= lut_wdata;
  end

  assign pix = m3ReadBus;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    output_lane #(.VEC_W(VEC_W)) u_lane (
      .lut (lut),
      .pix (pix[i]),
      .eq  (eq[i])
    );
  end
endmodule

// File: tb/tb_output_pipeline.sv
// Directed bench for output_pipeline: small 4-word image, 64-pixel divisor base.
module tb_output_pipeline;
  logic         clock = 1'b0;
  logic         rst, start, inputBaseOffset;
  logic [19:0]  cdf_min;
  logic [35:0]  m2ReadBus;
  logic [127:0] m3ReadBus;
  logic [15:0]  m2ReadAddr, m3ReadAddr, m4WriteAddr;
  logic [127:0] m4WriteBus;
  logic         m4WE, output_done;

  int checks = 0;
  int errors = 0;
  logic [19:0]  cdf_tab [256];
  logic [127:0] img     [4];
  logic [127:0] m4mem   [4];
  int           wr_total = 0;

  always #5 clock = ~clock;

  output_pipeline #(.ADDRESS_OF_LAST(15'd3), .TOTAL_PIXELS(20'd64)) dut (
    .clock           (clock),
    .rst             (rst),
    .start           (start),
    .inputBaseOffset (inputBaseOffset),
    .cdf_min         (cdf_min),
    .m2ReadBus       (m2ReadBus),
    .m3ReadBus       (m3ReadBus),
    .m2ReadAddr      (m2ReadAddr),
    .m3ReadAddr      (m3ReadAddr),
    .m4WriteAddr     (m4WriteAddr),
    .m4WriteBus      (m4WriteBus),
    .m4WE            (m4WE),
    .output_done     (output_done)
  );

  // one-cycle-latency scratchpads and output capture
  always @(posedge clock) begin
    m2ReadBus <= {16'h0, cdf_tab[m2ReadAddr[7:0]]};
    m3ReadBus <= img[m3ReadAddr[1:0]];
    if (m4WE) begin
      m4mem[m4WriteAddr[1:0]] <= m4WriteBus;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_map(input int c, input int cmin);
    longint den, q;
    den = 64 - cmin;
    if (c < cmin || den == 0) return 8'h00;
    q = (longint'(c - cmin) * 255 + den / 2) / den;
    return (q > 255) ? 8'hFF : 8'(q);
  endfunction

  function automatic logic [127:0] exp_word(input int k, input int cmin);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_map(int'(cdf_tab[img[k][8*i +: 8]]), cmin);
    return r;
  endfunction

  task automatic load_ramp_img();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) img[k][8*i +: 8] = 8'(16*k + i);
  endtask

  task automatic load_ramp_cdf();
    for (int x = 0; x < 256; x++) cdf_tab[x] = (x + 1 > 64) ? 20'd64 : 20'(x + 1);
  endtask

  // counts cycles from the start edge to the first m3 issue (0x8000)
  task automatic run_to_map(output int n, output logic [15:0] m2_1, output logic [15:0] m2_31,
                            output logic [15:0] m2_32);
    n = 0; m2_1 = 'x; m2_31 = 'x; m2_32 = 'x;
    while (m3ReadAddr !== 16'h8000 && n < 10000) begin
      @(negedge clock);
      n++;
      if (n == 1)  m2_1  = m2ReadAddr;
      if (n == 31) m2_31 = m2ReadAddr;
      if (n == 32) m2_32 = m2ReadAddr;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (output_done !== 1'b1 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, output_done, 1'b1);
  endtask

  initial begin
    int n, base, seen;
    logic [15:0] m2a, m2b, m2c;
    logic [15:0] exp_m3 [8];
    logic        exp_we [8];
    logic        exp_dn [8];

    exp_m3 = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8003, 16'h8003, 16'h8003, 16'h8003};
    exp_we = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b1; inputBaseOffset = 1'b1; cdf_min = 20'd1;
    load_ramp_cdf();
    load_ramp_img();

    // reset has priority over start
    repeat (3) begin
      @(negedge clock);
      chk("rst_outs", {m2ReadAddr, m3ReadAddr, m4WriteAddr, m4WE, output_done}, '0);
      chk("rst_bus", m4WriteBus, '0);
    end
    rst  = 1'b0;
    base = wr_total;

    // ramp run, timing and addressing
    run_to_map(n, m2a, m2b, m2c);
    chk("ramp_lut_cycles", n, 7937);
    chk("ramp_m2_first", m2a, 16'h0000);
    chk("ramp_m2_hold", m2b, 16'h0000);
    chk("ramp_m2_next", m2c, 16'h0001);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clock);
      chk($sformatf("map_m3_%0d", j), m3ReadAddr, exp_m3[j]);
      chk($sformatf("map_we_%0d", j), m4WE, exp_we[j]);
      chk($sformatf("map_done_%0d", j), output_done, exp_dn[j]);
      if (exp_we[j]) chk($sformatf("map_waddr_%0d", j), m4WriteAddr, 16'h8000 + 16'(j - 2));
    end
    start = 1'b0;
    @(negedge clock);
    chk("done_fall", output_done, 1'b0);
    chk("idle_m3_zero", m3ReadAddr, 16'h0000);
    chk("ramp_wr_count", wr_total - base, 4);
    chk("ramp_word0", m4mem[0], 128'h3D393531_2D282420_1C181410_0C080400);
    chk("ramp_px32", m4mem[2][7:0], 8'd130);
    chk("ramp_px63", m4mem[3][127:120], 8'd255);
    for (int k = 0; k < 4; k++) chk($sformatf("ramp_word%0d_model", k), m4mem[k], exp_word(k, 1));

    // flat image: den == 0 forces every LUT entry to 0
    for (int x = 0; x < 256; x++) cdf_tab[x] = (x < 128) ? 20'd0 : 20'd64;
    for (int k = 0; k < 4; k++) img[k] = {16{8'h80}};
    cdf_min = 20'd64;
    @(negedge clock);
    base  = wr_total;
    start = 1'b1;
    wait_done("flat");
    chk("flat_wr_count", wr_total - base, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("flat_word%0d", k), m4mem[k], '0);
    start = 1'b0;
    repeat (2) @(negedge clock);

    // below-min entries map to 0; large CDF values clamp to 0xFF
    for (int x = 0; x < 256; x++) cdf_tab[x] = (x < 10) ? 20'd0 : 20'(4 * x);
    load_ramp_img();
    cdf_min = 20'd5;
    base  = wr_total;
    start = 1'b1;
    wait_done("clamp");
    chk("clamp_wr_count", wr_total - base, 4);
    chk("clamp_word0", m4mem[0], 128'hEEDCCBBA_A9970000_00000000_00000000);
    chk("clamp_word1", m4mem[1], {16{8'hFF}});
    for (int k = 0; k < 4; k++) chk($sformatf("clamp_word%0d_model", k), m4mem[k], exp_word(k, 5));
    start = 1'b0;
    repeat (2) @(negedge clock);

    // abort after the second write, then full rebuild
    load_ramp_cdf();
    cdf_min = 20'd1;
    base  = wr_total;
    start = 1'b1;
    run_to_map(n, m2a, m2b, m2c);
    chk("abort_lut_cycles", n, 7937);
    seen = 0;
    n    = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clock);
      n++;
      if (m4WE) seen++;
    end
    chk("abort_two_writes_seen", seen, 2);
    start = 1'b0;
    @(negedge clock);
    chk("abort_we_low", m4WE, 1'b0);
    chk("abort_m3_zero", m3ReadAddr, 16'h0000);
    repeat (3) @(negedge clock);
    chk("abort_we_stays_low", m4WE, 1'b0);
    chk("abort_done_low", output_done, 1'b0);
    chk("abort_wr_count", wr_total - base, 2);
    base  = wr_total;
    start = 1'b1;
    run_to_map(n, m2a, m2b, m2c);
    chk("restart_lut_cycles", n, 7937);
    chk("restart_m2_next", m2c, 16'h0001);
    wait_done("restart");
    chk("restart_wr_count", wr_total - base, 4);
    chk("restart_word0", m4mem[0], 128'h3D393531_2D282420_1C181410_0C080400);
    for (int k = 0; k < 4; k++) chk($sformatf("restart_word%0d_model", k), m4mem[k], exp_word(k, 1));
    start = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
